// File: rtl/mult5_pkg.sv
// Shared constants and types for the sequential shift-add multiplier core.
package mult5_pkg;

  localparam int WIDTH = 5;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : mult5_pkg

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous pad strobe plus rising-edge detect.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   start_d;
  logic                   start_s;

  assign start_s = sync_q[SYNC_STAGES-1];

  // NOTE: non-blocking assignments make every flop sample its pre-edge input, so the chain shifts one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      start_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      start_d <= start_s;
    end
  end

  assign rise = start_s & ~start_d;

endmodule : sync_edge_detect

// File: rtl/mult5_seq_core.sv
// Sequential unsigned shift-add multiplier: one partial-product step per cycle,
// started by a synchronised rising edge on a pad strobe.
module mult5_seq_core #(
  parameter int WIDTH       = mult5_pkg::WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic [WIDTH-1:0]   io_a,
  input  logic [WIDTH-1:0]   io_b,
  input  logic               io_start,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH+1:0] io_oeb
);

  import mult5_pkg::*;

  localparam int             CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             start_rise;
  logic             last_step;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_start_sync (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n),
    .async_in(io_start),
    .rise    (start_rise)
  );

  // One step: conditionally add the multiplicand into the high half, then shift {hi,lo} right.
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    hi_n = sum[WIDTH:1];
    lo_n = {sum[0], lo_q[WIDTH-1:1]};
  end

  assign last_step = (state_q == RUN) && (cnt_q == LAST_STEP);

  // NOTE: next state defaults to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_rise) state_d = RUN;
      RUN:  if (last_step)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (start_rise) begin
          a_q   <= io_a;
          lo_q  <= io_b;
          hi_q  <= '0;
          cnt_q <= '0;
        end
      end else begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q + 1'b1;
        if (last_step) begin
          product <= {hi_n, lo_n};
          done    <= 1'b1;
        end
      end
    end
  end

  assign busy   = (state_q == RUN);
  assign io_oeb = '0;

endmodule : mult5_seq_core
